// File: rtl/exmem_pipe_reg.sv
// EX->MEM pipeline stage register with valid/ready handshake, optional 2-entry
// skid buffer, flush-to-bubble and a saturating stall counter.
module exmem_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 3,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrlE,
  input  logic [DATA_W-1:0] aluoutE,
  input  logic [DATA_W-1:0] wridataE,
  input  logic [REG_W-1:0]  wriregE,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrlM,
  output logic [DATA_W-1:0] aluoutM,
  output logic [DATA_W-1:0] wridataM,
  output logic [REG_W-1:0]  wriregM,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        dbg_state
);

  // Handshake: a transfer happens on any edge where valid and ready are both 1;
  // valid never depends on ready, and a raised valid holds its payload until taken.

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state, state_n;
  logic              accept;
  logic              load_main_in, load_main_skid, load_skid;
  logic [CTRL_W-1:0] ctrl_main, ctrl_skid;
  logic [DATA_W-1:0] alu_skid, wd_skid;
  logic [REG_W-1:0]  reg_skid;

  assign out_valid = (state != EMPTY);
  // With the skid buffer, ready comes straight from the state flop so there is
  // no combinational path from out_ready back to the EX stage.
  assign in_ready  = (SKID != 0) ? (state != TWO) : (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;
  assign ctrlM     = ctrl_main & {CTRL_W{out_valid}};
  assign dbg_state = state;

  always_comb begin
    state_n = state;
    case (state)
      EMPTY: if (accept) state_n = ONE;
      ONE: begin
        if (accept && !out_ready) begin
          if (SKID != 0) state_n = TWO;
        end else if (!accept && out_ready) begin
          state_n = EMPTY;
        end
      end
      TWO:     if (out_ready) state_n = ONE;
      default: state_n = EMPTY;
    endcase
    if (flush) state_n = EMPTY;
  end

  assign load_main_in   = accept & ~flush &
                          ((state == EMPTY) | ((state == ONE) & out_ready));
  assign load_main_skid = ~flush & (state == TWO) & out_ready;
  assign load_skid      = accept & ~flush & (state == ONE) & ~out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= EMPTY;
      ctrl_main <= '0;
      aluoutM   <= '0;
      wridataM  <= '0;
      wriregM   <= '0;
      ctrl_skid <= '0;
      alu_skid  <= '0;
      wd_skid   <= '0;
      reg_skid  <= '0;
      stall_cnt <= '0;
    end else begin
      state <= state_n;
      if (load_main_in) begin
        ctrl_main <= ctrlE;
        aluoutM   <= aluoutE;
        wridataM  <= wridataE;
        wriregM   <= wriregE;
      end else if (load_main_skid) begin
        ctrl_main <= ctrl_skid;
        aluoutM   <= alu_skid;
        wridataM  <= wd_skid;
        wriregM   <= reg_skid;
      end
      if (load_skid) begin
        ctrl_skid <= ctrlE;
        alu_skid  <= aluoutE;
        wd_skid   <= wridataE;
        reg_skid  <= wriregE;
      end
      // Flush does not clear the counter; only reset does.
      if (out_valid && !out_ready && stall_cnt != CNT_MAX)
        stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// Bench for exmem_pipe_reg: a skid instance (SKID=1, CNT_W=4) and a single-entry
// instance (SKID=0, CNT_W=16) share stimulus and are checked against a FIFO model.
module tb_exmem_pipe_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0]  ctrlE = '0;
  logic [31:0] aluoutE = '0, wridataE = '0;
  logic [4:0]  wriregE = '0;

  logic        s_rdy, s_vld, f_rdy, f_vld;
  logic [2:0]  s_ctl, f_ctl;
  logic [31:0] s_alu, s_wd, f_alu, f_wd;
  logic [4:0]  s_wr, f_wr;
  logic [3:0]  s_cnt;
  logic [15:0] f_cnt;
  logic [1:0]  s_st, f_st;

  int tests = 0, fails = 0;
  bit known = 0;

  // Reference model: per instance, an ordered list of held entries.
  logic [2:0]  m_ctl[2][2];
  logic [31:0] m_alu[2][2], m_wd[2][2];
  logic [4:0]  m_wr[2][2];
  int          n[2], scnt[2];
  logic [31:0] h_alu[2], h_wd[2];
  logic [4:0]  h_wr[2];
  bit          flushed[2], acc[2];
  logic [31:0] rec;

  exmem_pipe_reg #(.SKID(1), .CNT_W(4)) u_skid (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_rdy),
    .ctrlE(ctrlE), .aluoutE(aluoutE), .wridataE(wridataE), .wriregE(wriregE),
    .out_valid(s_vld), .out_ready(out_ready), .ctrlM(s_ctl), .aluoutM(s_alu),
    .wridataM(s_wd), .wriregM(s_wr), .stall_cnt(s_cnt), .dbg_state(s_st)
  );

  exmem_pipe_reg #(.SKID(0), .CNT_W(16)) u_flop (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(f_rdy),
    .ctrlE(ctrlE), .aluoutE(aluoutE), .wridataE(wridataE), .wriregE(wriregE),
    .out_valid(f_vld), .out_ready(out_ready), .ctrlM(f_ctl), .aluoutM(f_alu),
    .wridataM(f_wd), .wriregM(f_wr), .stall_cnt(f_cnt), .dbg_state(f_st)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input int d);
    int maxc;
    maxc = (d == 1) ? 15 : 65535;
    if (!rst_n) begin
      n[d] = 0; scnt[d] = 0; flushed[d] = 0;
      h_alu[d] = '0; h_wd[d] = '0; h_wr[d] = '0;
    end else begin
      if (n[d] > 0 && !out_ready && scnt[d] < maxc) scnt[d]++;
      if (flush) begin
        n[d] = 0;
        flushed[d] = 1;
      end else begin
        if (n[d] > 0 && out_ready) begin
          m_ctl[d][0] = m_ctl[d][1]; m_alu[d][0] = m_alu[d][1];
          m_wd[d][0]  = m_wd[d][1];  m_wr[d][0]  = m_wr[d][1];
          n[d]--;
        end
        if (acc[d]) begin
          m_ctl[d][n[d]] = ctrlE; m_alu[d][n[d]] = aluoutE;
          m_wd[d][n[d]]  = wridataE; m_wr[d][n[d]] = wriregE;
          n[d]++;
        end
      end
      if (n[d] > 0) begin
        h_alu[d] = m_alu[d][0]; h_wd[d] = m_wd[d][0]; h_wr[d] = m_wr[d][0];
      end
    end
  endtask

  task automatic check_out(input int d, input string p, input logic vld,
                           input logic [2:0] ctl, input logic [31:0] alu,
                           input logic [31:0] wd, input logic [4:0] wr,
                           input logic [15:0] cnt, input logic [1:0] st);
    chk({p, "_out_valid"}, vld, n[d] > 0);
    chk({p, "_ctrlM"}, ctl, (n[d] > 0) ? m_ctl[d][0] : 3'b000);
    chk({p, "_stall_cnt"}, cnt, scnt[d]);
    chk({p, "_occupancy"}, st, n[d]);
    if (n[d] > 0 || !flushed[d]) begin
      chk({p, "_aluoutM"},  alu, (n[d] > 0) ? m_alu[d][0] : h_alu[d]);
      chk({p, "_wridataM"}, wd,  (n[d] > 0) ? m_wd[d][0]  : h_wd[d]);
      chk({p, "_wriregM"},  wr,  (n[d] > 0) ? m_wr[d][0]  : h_wr[d]);
    end
  endtask

  task automatic tick();
    bit er0, er1;
    #1;
    er1 = (n[1] < 2);
    er0 = (n[0] == 0) || out_ready;
    if (known) begin
      chk("s_in_ready", s_rdy, er1);
      chk("f_in_ready", f_rdy, er0);
    end
    acc[1] = in_valid && er1 && rst_n;
    acc[0] = in_valid && er0 && rst_n;
    @(posedge clk);
    #1;
    model_edge(1);
    model_edge(0);
    if (!rst_n) known = 1;
    check_out(1, "s", s_vld, s_ctl, s_alu, s_wd, s_wr, {12'b0, s_cnt}, s_st);
    check_out(0, "f", f_vld, f_ctl, f_alu, f_wd, f_wr, f_cnt, f_st);
  endtask

  task automatic drive(input logic v, input logic r, input logic [31:0] alu,
                       input logic [2:0] ctl);
    in_valid = v; out_ready = r; aluoutE = alu; ctrlE = ctl;
    wridataE = $urandom; wriregE = 5'($urandom_range(0, 31));
  endtask

  initial begin
    n[0] = 0; n[1] = 0; scnt[0] = 0; scnt[1] = 0;

    // Reset held two edges with in_valid high.
    drive(1, 0, 32'h55, 3'b111);
    tick(); tick();
    chk("rst_s_aluoutM", s_alu, 32'h0);
    chk("rst_s_out_valid", s_vld, 1'b0);
    rst_n = 1;
    drive(0, 1, 32'h0, 3'b000);
    #1;
    chk("rst_s_in_ready", s_rdy, 1'b1);

    // Streaming with out_ready held high.
    drive(1, 1, 32'h11, 3'b001); tick(); chk("stream_11", s_alu, 32'h11);
    drive(1, 1, 32'h22, 3'b001); tick(); chk("stream_22", s_alu, 32'h22);
    drive(1, 1, 32'h33, 3'b001); tick(); chk("stream_33", s_alu, 32'h33);
    chk("stream_f_33", f_alu, 32'h33);
    chk("stream_ctrl", s_ctl, 3'b001);
    drive(0, 1, 32'h0, 3'b000); tick();

    // Backpressure into the skid entry.
    drive(1, 1, 32'hA, 3'b101); tick();
    drive(1, 0, 32'hB, 3'b011); tick();
    chk("bp_in_ready_two", s_rdy, 1'b0);
    chk("bp_hold_A", s_alu, 32'hA);
    rec = 32'(s_cnt);
    drive(0, 0, 32'h0, 3'b000); tick();
    chk("bp_stall_inc", 32'(s_cnt), rec + 1);
    chk("bp_still_A", s_alu, 32'hA);
    drive(0, 1, 32'h0, 3'b000); tick();
    chk("bp_then_B", s_alu, 32'hB);
    chk("bp_B_ctrl", s_ctl, 3'b011);
    tick();
    chk("bp_drained", s_vld, 1'b0);

    // Flush with both entries full and a new input offered.
    drive(1, 0, 32'hD, 3'b001); tick();
    drive(1, 0, 32'hE, 3'b001); tick();
    rec = 32'(s_cnt);
    flush = 1;
    drive(1, 1, 32'hC, 3'b111); tick();
    flush = 0;
    chk("fl_out_valid", s_vld, 1'b0);
    chk("fl_ctrlM", s_ctl, 3'b000);
    chk("fl_stall_same", 32'(s_cnt), rec);
    drive(0, 1, 32'h0, 3'b000); tick();
    chk("fl_no_C", s_vld, 1'b0);

    // Single-entry instance: ready follows out_ready combinationally.
    drive(1, 1, 32'h71, 3'b001); tick();
    drive(1, 0, 32'h72, 3'b001);
    #1;
    chk("nos_ready_low", f_rdy, 1'b0);
    tick();
    chk("nos_hold", f_alu, 32'h71);
    drive(1, 1, 32'h73, 3'b001);
    #1;
    chk("nos_ready_high", f_rdy, 1'b1);
    tick();
    chk("nos_replace", f_alu, 32'h73);
    drive(0, 1, 32'h0, 3'b000); tick(); tick();

    // Stall counter saturation on the 4-bit instance.
    drive(1, 0, 32'h99, 3'b010); tick();
    drive(0, 0, 32'h0, 3'b000);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_15", s_cnt, 4'd15);
    tick();
    chk("sat_stays", s_cnt, 4'd15);

    // Randomised traffic.
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            $urandom, 3'($urandom_range(0, 7)));
      flush = ($urandom_range(0, 19) == 0);
      tick();
    end
    flush = 0;

    // Final reset clears everything including the counter.
    rst_n = 0;
    drive(1, 0, 32'h0, 3'b111);
    tick();
    chk("end_rst_cnt", s_cnt, 4'd0);
    rst_n = 1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
